// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// irq_arbiter - N-source edge-triggered interrupt arbiter driving meip_o,
//               with claim (ack_i) / complete handshake and register file.
// Rev 1.0
// ============================================================================
module irq_arbiter #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic [3:0]       reg_addr_i,
    input  logic [31:0]      reg_wdata_i,
    input  logic             reg_wen_i,
    output logic [31:0]      reg_rdata_o,
    input  logic             ack_i,
    output logic             meip_o,
    output logic [3:0]       claim_id_o
);

    localparam logic [3:0] ADDR_ENABLE    = 4'h0;
    localparam logic [3:0] ADDR_PENDING   = 4'h1;
    localparam logic [3:0] ADDR_THRESHOLD = 4'h2;
    localparam logic [3:0] ADDR_CLAIM     = 4'h3;
    localparam logic [3:0] ADDR_COMPLETE  = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  sync1_q, sync2_q, hist_q;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q;
    logic [PRIO_W-1:0] threshold_q;
    logic [PRIO_W-1:0] prio_q [N_SRC];
    logic              best_valid_q, best_valid_d;
    logic [3:0]        best_id_q, best_id_d;
    logic [PRIO_W-1:0] best_prio;
    logic [3:0]        claim_id_q, claim_id_d;
    logic              meip_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              wr;
    logic              claim_fire;
    logic              complete_hit;
    logic [N_SRC-1:0]  src_rise;
    logic [N_SRC-1:0]  wr_clr;
    logic [N_SRC-1:0]  claim_clr;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    assign wr           = ~reg_wen_i;
    assign src_rise     = sync2_q & ~hist_q;
    assign complete_hit = wr && (reg_addr_i == ADDR_COMPLETE) &&
                          (reg_wdata_i[3:0] == claim_id_q);
    assign wr_clr       = (wr && reg_addr_i == ADDR_PENDING) ? reg_wdata_i[N_SRC-1:0] : '0;
    assign claim_clr    = claim_fire ? ((N_SRC)'(1) << best_id_q) : '0;

    // A new edge outranks any clear of the same bit in the same cycle.
    assign pending_d = (pending_q & ~wr_clr & ~claim_clr) | (src_rise & enable_q);

    always_comb begin
        best_valid_d = 1'b0;
        best_id_d    = '0;
        best_prio    = threshold_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
                best_valid_d = 1'b1;
                best_id_d    = 4'(i);
                best_prio    = prio_q[i];
            end
        end
        // Held low in service so a post-complete request waits one full re-evaluation.
        if (state_q == ST_SVC) begin
            best_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        claim_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (best_valid_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    claim_fire = 1'b1;
                    claim_id_d = best_id_q + 4'd1;
                    state_d    = ST_SVC;
                end else if (!best_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (complete_hit) begin
                    claim_id_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (reg_addr_i)
            ADDR_ENABLE:    rdata_d[N_SRC-1:0]  = enable_q;
            ADDR_PENDING:   rdata_d[N_SRC-1:0]  = pending_q;
            ADDR_THRESHOLD: rdata_d[PRIO_W-1:0] = threshold_q;
            ADDR_CLAIM:     rdata_d[3:0]        = claim_id_q;
            default: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (reg_addr_i == 4'(8 + i)) begin
                        rdata_d[PRIO_W-1:0] = prio_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            threshold_q  <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            claim_id_q   <= '0;
            meip_q       <= 1'b0;
            rdata_q      <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sync1_q      <= src_i;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            pending_q    <= pending_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            claim_id_q   <= claim_id_d;
            meip_q       <= (state_d == ST_REQ);
            rdata_q      <= rdata_d;
            if (wr && reg_addr_i == ADDR_ENABLE) begin
                enable_q <= reg_wdata_i[N_SRC-1:0];
            end
            if (wr && reg_addr_i == ADDR_THRESHOLD) begin
                threshold_q <= reg_wdata_i[PRIO_W-1:0];
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (wr && reg_addr_i == 4'(8 + i)) begin
                    prio_q[i] <= reg_wdata_i[PRIO_W-1:0];
                end
            end
        end
    end

    assign meip_o      = meip_q;
    assign claim_id_o  = claim_id_q;
    assign reg_rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// tb_irq_arbiter - directed self-checking bench for irq_arbiter.
// Rev 1.0
// ============================================================================
module tb_irq_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [7:0]  src_i = '0;
    logic [3:0]  reg_addr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic        reg_wen_i = 1'b1;
    logic [31:0] reg_rdata_o;
    logic        ack_i = 1'b0;
    logic        meip_o;
    logic [3:0]  claim_id_o;

    int n_checks = 0;
    int n_fail   = 0;

    irq_arbiter #(.N_SRC(8), .PRIO_W(3)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .src_i       (src_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wen_i   (reg_wen_i),
        .reg_rdata_o (reg_rdata_o),
        .ack_i       (ack_i),
        .meip_o      (meip_o),
        .claim_id_o  (claim_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        reg_addr_i  = a;
        reg_wdata_i = d;
        reg_wen_i   = 1'b0;
        @(negedge clk_i);
        reg_wen_i   = 1'b1;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_i);
        reg_addr_i = a;
        @(negedge clk_i);
        d = reg_rdata_o;
    endtask

    task automatic fire(input logic [7:0] mask);
        @(negedge clk_i);
        src_i = mask;
        @(negedge clk_i);
        src_i = '0;
    endtask

    task automatic pulse_ack();
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
    endtask

    task automatic wait_meip(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (meip_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2;
        n_checks++;
        if (meip_o !== 1'b0 || claim_id_o !== 4'd0 || reg_rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: meip=%b claim=%0d rdata=%h, want 0 0 0", meip_o, claim_id_o, reg_rdata_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        reg_read(4'h0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_enable: got %h want 0", d); end
        reg_read(4'h8, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_prio0: got %h want 0", d); end
    endtask

    task automatic test_single_source();
        logic [31:0] d;
        bit ok;
        reg_write(4'h0, 32'h01);
        reg_write(4'h8, 32'h1);
        reg_write(4'h2, 32'h0);
        reg_read(4'h0, d);
        n_checks++;
        if (d !== 32'h01) begin n_fail++; $display("FAIL enable_rw: got %h want 01", d); end
        @(negedge clk_i);
        src_i = 8'h01;
        @(posedge clk_i);
        @(negedge clk_i);
        src_i = '0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: meip=%b want 0 at k+3", meip_o); end
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b1) begin n_fail++; $display("FAIL single_latency: meip=%b want 1 at k+4", meip_o); end
        pulse_ack();
        n_checks++;
        if (claim_id_o !== 4'd1 || meip_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_claim: claim=%0d meip=%b want 1 0", claim_id_o, meip_o);
        end
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL single_pending: got %h want 0", d); end
        reg_read(4'h3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL single_claim_reg: got %h want 1", d); end
        reg_write(4'h4, 32'h1);
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (claim_id_o !== 4'd0 || meip_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_complete: claim=%0d meip=%b want 0 0", claim_id_o, meip_o);
        end
        ok = 1'b1;
    endtask

    task automatic test_arbitration();
        logic [31:0] d;
        logic [3:0] exp_ids [3];
        bit ok;
        exp_ids[0] = 4'd3;
        exp_ids[1] = 4'd6;
        exp_ids[2] = 4'd2;
        reg_write(4'hA, 32'h3);
        reg_write(4'hD, 32'h3);
        reg_write(4'h9, 32'h2);
        reg_write(4'h0, 32'h26);
        fire(8'h26);
        for (int n = 0; n < 3; n++) begin
            wait_meip(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL arb_meip_timeout: round %0d meip=%b want 1", n, meip_o); end
            pulse_ack();
            n_checks++;
            if (claim_id_o !== exp_ids[n]) begin
                n_fail++;
                $display("FAIL arb_order: round %0d claim=%0d want %0d", n, claim_id_o, exp_ids[n]);
            end
            if (n == 0) begin
                reg_read(4'h1, d);
                n_checks++;
                if (d !== 32'h22) begin n_fail++; $display("FAIL arb_pending: got %h want 22", d); end
            end
            reg_write(4'h4, {28'd0, exp_ids[n]});
        end
        repeat (6) @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0 || claim_id_o !== 4'd0) begin
            n_fail++;
            $display("FAIL arb_drain: meip=%b claim=%0d want 0 0", meip_o, claim_id_o);
        end
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        reg_write(4'h0, 32'h01);
        reg_write(4'h8, 32'h2);
        reg_write(4'h2, 32'h2);
        fire(8'h01);
        repeat (8) @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL thr_block: meip=%b want 0", meip_o); end
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'h01) begin n_fail++; $display("FAIL thr_pending: got %h want 01", d); end
        reg_write(4'h2, 32'h1);
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL thr_lower_early: meip=%b want 0", meip_o); end
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b1) begin n_fail++; $display("FAIL thr_lower: meip=%b want 1", meip_o); end
    endtask

    task automatic test_withdrawal();
        logic [31:0] d;
        reg_write(4'h0, 32'h00);
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b1) begin n_fail++; $display("FAIL wd_hold: meip=%b want 1", meip_o); end
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL wd_drop: meip=%b want 0", meip_o); end
        pulse_ack();
        @(negedge clk_i);
        n_checks++;
        if (claim_id_o !== 4'd0 || meip_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_late_ack: claim=%0d meip=%b want 0 0", claim_id_o, meip_o);
        end
        reg_write(4'h1, 32'h01);
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL wd_w1c: got %h want 0", d); end
        reg_write(4'h2, 32'h0);
    endtask

    task automatic test_complete_mismatch();
        logic [31:0] d;
        bit ok;
        reg_write(4'h0, 32'h01);
        fire(8'h01);
        wait_meip(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL cm_meip_timeout: meip=%b want 1", meip_o); end
        pulse_ack();
        reg_write(4'h4, 32'h2);
        @(negedge clk_i);
        n_checks++;
        if (claim_id_o !== 4'd1) begin n_fail++; $display("FAIL cm_mismatch: claim=%0d want 1", claim_id_o); end
        fire(8'h01);
        repeat (4) @(negedge clk_i);
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'h01 || meip_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cm_retrigger: pending=%h meip=%b want 01 0", d, meip_o);
        end
        reg_write(4'h4, 32'h1);
        n_checks++;
        if (claim_id_o !== 4'd0) begin n_fail++; $display("FAIL cm_complete: claim=%0d want 0", claim_id_o); end
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL cm_reassert_early: meip=%b want 0 at c+1", meip_o); end
        @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b1) begin n_fail++; $display("FAIL cm_reassert: meip=%b want 1 at c+2", meip_o); end
        pulse_ack();
        n_checks++;
        if (claim_id_o !== 4'd1) begin n_fail++; $display("FAIL cm_reclaim: claim=%0d want 1", claim_id_o); end
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        reg_write(4'h0, 32'hFF);
        fire(8'hFF);
        repeat (5) @(negedge clk_i);
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'hFF) begin n_fail++; $display("FAIL rst_pre_pending: got %h want ff", d); end
        #2;
        reset_i = 1'b0;
        #1;
        n_checks++;
        if (meip_o !== 1'b0 || claim_id_o !== 4'd0 || reg_rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: meip=%b claim=%0d rdata=%h want 0 0 0", meip_o, claim_id_o, reg_rdata_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        reg_read(4'h3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rst_claim: got %h want 0", d); end
        reg_read(4'h1, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", d); end
        repeat (10) @(negedge clk_i);
        n_checks++;
        if (meip_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_meip: meip=%b want 0", meip_o); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_arbitration();
        test_threshold();
        test_withdrawal();
        test_complete_mismatch();
        test_reset_mid_service();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
# irq_arbiter

Platform interrupt arbiter that multiplexes `N_SRC` peripheral interrupt lines onto the core's single machine external interrupt input (`meip_i` of the CSR unit). It synchronises and latches source events, picks the highest-priority enabled pending source above a programmable threshold, and raises `meip_o`. It then runs a claim/complete handshake: the CSR unit's one-cycle `ack_o` pulse is the claim, and a software write to COMPLETE ends service. Configuration is through a small memory-mapped register file on the data bus.

## Interface
- `N_SRC`, 8: number of interrupt sources, 1..8.
- `PRIO_W`, 3: priority field width. Priority 0 means never interrupt.
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `src_i`  in  N_SRC  asynchronous interrupt sources; rising-edge triggered.
- `reg_addr_i`  in  4  register word address.
- `reg_wdata_i`  in  32  write data.
- `reg_wen_i`  in  1  write enable, active-low (bus convention).
- `reg_rdata_o`  out  32  registered read data.
- `ack_i`  in  1  claim pulse from the CSR unit's `ack_o`.
- `meip_o`  out  1  external interrupt request to the CSR unit's `meip_i`.
- `claim_id_o`  out  4  in-service source index+1; 0 when idle.

## Operation
- Register map (word addresses):
  - 0x0 ENABLE [N_SRC-1:0], RW.
  - 0x1 PENDING, RO; a write-1 clears the written bits.
  - 0x2 THRESHOLD [PRIO_W-1:0], RW.
  - 0x3 CLAIM, RO: `{28'b0, claim_id}`.
  - 0x4 COMPLETE, WO: `wdata[3:0]` is the id being completed.
  - 0x8+i PRIORITY[i], RW, for i < N_SRC.
  - Other addresses read 0 and ignore writes. Unimplemented bits read 0.
- Input path: each `src_i` goes through a 2-flop synchroniser plus a history flop. A rising edge sets `pending[i]` only if `enable[i]` is 1. Edges on disabled sources are dropped.
- Candidate selection: consider sources with `pending & enable` and `prio > threshold`. The highest priority wins; ties go to the lowest index. The result is registered each cycle as `best_valid` / `best_id`.
- FSM, 3 states:
  - IDLE: `meip_o`=0. Go to REQ when `best_valid`=1.
  - REQ: `meip_o`=1.
    - If `ack_i`=1: `claim_id` ← `best_id`+1, clear `pending[best_id]`, go to SVC.
    - Else if `best_valid`=0 (source disabled, cleared, or threshold raised): go to IDLE.
  - SVC: `meip_o`=0, no new requests (no nesting). A COMPLETE write whose id equals `claim_id` sets `claim_id` ← 0 and goes to IDLE. A mismatched COMPLETE write is ignored.
- `ack_i` outside REQ is ignored.
- Simultaneous events:
  - Source edge in the same cycle as a write-1-clear or claim of that bit: the set wins, and the bit stays pending.
  - ENABLE write in the same cycle as an edge: the old enable value qualifies the edge.
- Reset, including mid-service: all registers and pending bits are 0, FSM goes to IDLE, `meip_o`=0, `claim_id_o`=0, `reg_rdata_o`=0. Synchroniser flops reset to 0, so a source held high at reset release produces an edge.

## Timing
- All state updates on `posedge clk_i`.
- Read latency is 1 cycle: `reg_rdata_o` reflects the address sampled at the previous edge and holds otherwise.
- Write takes effect at the edge where `reg_wen_i`=0.
- Source latency: `src_i` rises before edge k → synchroniser captures at k and k+1 → pending set at k+2 → `best_valid` at k+3 → `meip_o`=1 after edge k+4.
- Claim: `ack_i` high at edge m → `meip_o`=0 and `claim_id_o` valid after m.
- Complete: write at edge c → state IDLE after c. If another candidate is pending, `meip_o` reasserts after c+2, because `best_valid` is re-evaluated one cycle after IDLE.
- `meip_o` and `claim_id_o` are direct flop outputs (glitch-free for the CSR unit's negedge sampling).

## Test plan
- Single source:
  - Setup: ENABLE=0x01, PRIO[0]=1, THRESHOLD=0.
  - Pulse `src_i[0]`.
  - `meip_o`=1 at k+4. `ack_i` pulse → `claim_id_o`=1, PENDING=0, `meip_o`=0.
  - COMPLETE=1 → IDLE.
- Arbitration:
  - Setup: sources 2 and 5 at priority 3, source 1 at priority 2, all enabled; fire all three in the same cycle.
  - Claims come out in order 3, 6, 2, with each following COMPLETE.
- Threshold:
  - Setup: PRIO[0]=2, THRESHOLD=2; fire source 0.
  - PENDING=0x01 and `meip_o` stays 0.
  - Write THRESHOLD=1 → `meip_o`=1 two cycles later.
- Withdrawal:
  - In REQ, clear ENABLE before `ack_i` → FSM goes to IDLE and `meip_o`=0.
  - A later `ack_i` is ignored and `claim_id_o` stays 0.
- Complete mismatch and re-trigger:
  - In SVC with id 1, write COMPLETE=2 → remains SVC.
  - Fire source 0 again during service → PENDING bit set again.
  - COMPLETE=1 → `meip_o` reasserts.
- Reset mid-service:
  - Drive `reset_i` low asynchronously while in SVC with PENDING=0xFF.
  - All outputs read 0 immediately.
  - After release, CLAIM reads 0 and no `meip_o`.
